mdriver_arbiter: RTL and testbench

Round-robin arbiter that lets NREQ independent requesters share the single AXI-lite master driver, which accepts one transaction at a time. The block sits between the requesters and the driver's mdriver port. It grants one requester at a time and holds that requester's command stable on the driver until the driver pulses fin. It then returns completion and read data to the granted requester only.

---
 rtl/mdriver_arb_pkg.sv | 16 +
 rtl/mdriver_arbiter_rr_arbiter.sv | 45 ++++
 rtl/mdriver_arbiter.sv | 131 +++++++++++++
 tb/tb_mdriver_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdriver_arb_pkg.sv
// Shared types and helpers for the AXI-lite master driver arbiter.
package mdriver_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    // Width of a requester index for an n-entry request vector, never below one bit.
    function automatic int unsigned rr_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mdriver_arbiter_rr_arbiter.sv
// Combinational round-robin pick: rotate by ptr, take the lowest set bit, rotate back.
module rr_arbiter
    import mdriver_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = rr_idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [IW-1:0]   grant_o,
    output logic            any_req_o
);

    logic [NREQ-1:0] rot;
    logic [IW-1:0]   first;
    logic            found;

    function automatic logic [IW-1:0] wrap(input logic [IW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        return IW'(s % NREQ);
    endfunction

    always_comb begin
        rot = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            rot[k] = req_i[wrap(ptr_i, k)];
        end
    end

    always_comb begin
        first = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!found && rot[k]) begin
                first = IW'(k);
                found = 1'b1;
            end
        end
    end

    assign grant_o   = wrap(ptr_i, 32'(first));
    assign any_req_o = |req_i;

endmodule

// File: rtl/mdriver_arbiter.sv
// Round-robin arbiter sharing one single-outstanding AXI-lite master driver among NREQ requesters.
module mdriver_arbiter
    import mdriver_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned AW   = 32,
    parameter int unsigned DW   = 32
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic [NREQ-1:0]          req_exec,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ*AW-1:0]       req_addr,
    input  logic [NREQ*DW-1:0]       req_wdata,
    output logic [NREQ-1:0]          req_fin,
    output logic [DW-1:0]            req_rdata,
    output logic                     busy,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     m_exec,
    output logic                     m_we,
    output logic [AW-1:0]            m_address,
    output logic [DW-1:0]            m_data,
    input  logic                     m_fin,
    input  logic [DW-1:0]            m_rdata
);

    localparam int unsigned IW = $clog2(NREQ);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] grant_q, grant_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic [IW-1:0] pick;
    logic          any_req;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req_i     (req_exec),
        .ptr_i     (ptr_q),
        .grant_o   (pick),
        .any_req_o (any_req)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (pick == IW'(k)) begin
                sel_we    = req_we[k];
                sel_addr  = req_addr[k*AW +: AW];
                sel_wdata = req_wdata[k*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = pick;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (m_fin) begin
                    if (!we_q) rdata_d = m_rdata;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Advance past the grantee so a held request drops to lowest priority.
                if (32'(grant_q) == NREQ - 1) ptr_d = '0;
                else                          ptr_d = grant_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Command registers drive the driver in every state so they stay stable through WAIT.
    assign m_exec    = (state_q == ISSUE);
    assign m_we      = we_q;
    assign m_address = addr_q;
    assign m_data    = wdata_q;
    assign busy      = (state_q != IDLE);
    assign grant_id  = grant_q;
    assign req_rdata = rdata_q;
    assign req_fin   = (state_q == DONE) ? (NREQ'(1) << grant_q) : '0;

endmodule

// File: tb/tb_mdriver_arbiter.sv
// Self-checking bench for mdriver_arbiter: directed scenarios plus a randomized run against a queue-based model.
module tb_mdriver_arbiter;

    logic         clk = 1'b0;
    logic         nreset;
    logic [3:0]   req_exec, req_we, req_fin;
    logic [127:0] req_addr, req_wdata;
    logic [31:0]  req_rdata, m_address, m_data, m_rdata;
    logic         busy, m_exec, m_we, m_fin;
    logic [1:0]   grant_id;

    mdriver_arbiter #(.NREQ(4), .AW(32), .DW(32)) dut (
        .clk(clk), .nreset(nreset), .req_exec(req_exec), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_fin(req_fin),
        .req_rdata(req_rdata), .busy(busy), .grant_id(grant_id),
        .m_exec(m_exec), .m_we(m_we), .m_address(m_address), .m_data(m_data),
        .m_fin(m_fin), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   act;
        logic [3:0]   wes;
        logic [127:0] addrs;
        logic [127:0] wds;
        logic [31:0]  addr;
        logic         we;
        logic [31:0]  data;
        logic [1:0]   gid;
        logic         bsy;
        int           cyc;
    } exec_t;

    typedef struct {
        logic [3:0]  fin;
        logic [31:0] rdata;
        logic [31:0] sent;
        int          cyc;
        int          mfin;
    } fin_t;

    exec_t       exec_log[$];
    fin_t        fin_log[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          drv_active = 0;
    int          drv_cnt = 0;
    int          drv_lat = 2;
    bit          rand_lat = 0;
    bit          force_rd = 0;
    logic [31:0] force_val = '0;
    logic [31:0] last_sent = '0;
    logic [31:0] ex_addr, ex_data;
    logic        ex_we;
    int          unstable = 0;
    int          mfin_cyc = 0;
    logic [3:0]  hold_mask = '0;

    // One clock: driver model, logging, and drop-on-completion for non-holding requesters.
    task automatic step();
        exec_t      e;
        fin_t       f;
        logic [3:0] snap;
        @(negedge clk);
        cyc++;
        snap    = req_exec;
        m_fin   = 1'b0;
        m_rdata = $urandom;
        if (!nreset) begin
            drv_active = 0;
        end else if (m_exec) begin
            e.act = snap; e.wes = req_we; e.addrs = req_addr; e.wds = req_wdata;
            e.addr = m_address; e.we = m_we; e.data = m_data; e.gid = grant_id;
            e.bsy = busy; e.cyc = cyc;
            exec_log.push_back(e);
            ex_addr = m_address; ex_we = m_we; ex_data = m_data;
            drv_active = 1;
            drv_cnt = rand_lat ? int'($urandom_range(1, 4)) : drv_lat;
        end else if (drv_active) begin
            if (m_address !== ex_addr || m_we !== ex_we || m_data !== ex_data) unstable++;
            drv_cnt--;
            if (drv_cnt == 0) begin
                m_fin = 1'b1;
                m_rdata = force_rd ? force_val : $urandom;
                last_sent = m_rdata;
                mfin_cyc = cyc;
                drv_active = 0;
            end
        end
        if (req_fin !== 4'b0000) begin
            f.fin = req_fin; f.rdata = req_rdata; f.sent = last_sent;
            f.cyc = cyc; f.mfin = mfin_cyc;
            fin_log.push_back(f);
            req_exec = req_exec & ~(req_fin & ~hold_mask);
        end
    endtask

    task automatic run_fins(input int n, input int budget, output bit ok);
        int k = 0;
        while (fin_log.size() < n && k < budget) begin
            step();
            k++;
        end
        ok = (fin_log.size() >= n);
    endtask

    task automatic idle_steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic clear_logs();
        exec_log.delete();
        fin_log.delete();
        unstable = 0;
    endtask

    task automatic do_reset();
        req_exec = '0;
        nreset = 1'b0;
        step();
        step();
        nreset = 1'b1;
        step();
    endtask

    task automatic test_reset();
        req_exec = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        m_fin = 1'b0; m_rdata = '0;
        nreset = 1'b0;
        step();
        step();
        checks++; if (m_exec !== 1'b0)     begin errors++; $display("FAIL reset_m_exec: got %b expected 0", m_exec); end
        checks++; if (m_we !== 1'b0)       begin errors++; $display("FAIL reset_m_we: got %b expected 0", m_we); end
        checks++; if (m_address !== '0)    begin errors++; $display("FAIL reset_m_address: got %h expected 0", m_address); end
        checks++; if (m_data !== '0)       begin errors++; $display("FAIL reset_m_data: got %h expected 0", m_data); end
        checks++; if (req_fin !== 4'b0000) begin errors++; $display("FAIL reset_req_fin: got %b expected 0000", req_fin); end
        checks++; if (req_rdata !== '0)    begin errors++; $display("FAIL reset_req_rdata: got %h expected 0", req_rdata); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (grant_id !== 2'd0)   begin errors++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
        nreset = 1'b1;
        step();
    endtask

    task automatic test_single_read();
        bit ok;
        int c0;
        clear_logs();
        hold_mask = '0; rand_lat = 0; drv_lat = 3; force_rd = 1; force_val = 32'hDEADBEEF;
        req_we[2] = 1'b0; req_addr[64 +: 32] = 32'h10; req_wdata[64 +: 32] = 32'h0BADF00D;
        req_exec[2] = 1'b1;
        c0 = cyc;
        run_fins(1, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL read_timeout: got %0d fins expected 1", fin_log.size()); end
        idle_steps(6);
        checks++; if (exec_log.size() != 1) begin errors++; $display("FAIL read_exec_count: got %0d expected 1", exec_log.size()); end
        if (exec_log.size() > 0) begin
            checks++; if (exec_log[0].addr !== 32'h10) begin errors++; $display("FAIL read_addr: got %h expected 10", exec_log[0].addr); end
            checks++; if (exec_log[0].we !== 1'b0)     begin errors++; $display("FAIL read_we: got %b expected 0", exec_log[0].we); end
            checks++; if (exec_log[0].gid !== 2'd2)    begin errors++; $display("FAIL read_grant_id: got %0d expected 2", exec_log[0].gid); end
            checks++; if (exec_log[0].cyc - c0 != 1)   begin errors++; $display("FAIL read_exec_latency: got %0d expected 1", exec_log[0].cyc - c0); end
            checks++; if (exec_log[0].bsy !== 1'b1)    begin errors++; $display("FAIL read_busy_issue: got %b expected 1", exec_log[0].bsy); end
        end
        checks++; if (unstable != 0) begin errors++; $display("FAIL read_cmd_stable: got %0d changes expected 0", unstable); end
        if (fin_log.size() > 0) begin
            checks++; if (fin_log[0].fin !== 4'b0100)        begin errors++; $display("FAIL read_fin: got %b expected 0100", fin_log[0].fin); end
            checks++; if (fin_log[0].rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL read_rdata: got %h expected deadbeef", fin_log[0].rdata); end
            checks++; if (fin_log[0].cyc - fin_log[0].mfin != 1) begin errors++; $display("FAIL read_fin_latency: got %0d expected 1", fin_log[0].cyc - fin_log[0].mfin); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_busy_idle: got %b expected 0", busy); end
    endtask

    task automatic test_single_write();
        bit ok;
        clear_logs();
        drv_lat = 2; force_rd = 1; force_val = 32'h12345678;
        req_we[0] = 1'b1; req_addr[0 +: 32] = 32'h04; req_wdata[0 +: 32] = 32'hA5;
        req_exec[0] = 1'b1;
        run_fins(1, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL write_timeout: got %0d fins expected 1", fin_log.size()); end
        idle_steps(4);
        checks++; if (exec_log.size() != 1) begin errors++; $display("FAIL write_exec_count: got %0d expected 1", exec_log.size()); end
        if (exec_log.size() > 0) begin
            checks++; if (exec_log[0].we !== 1'b1)     begin errors++; $display("FAIL write_we: got %b expected 1", exec_log[0].we); end
            checks++; if (exec_log[0].data !== 32'hA5) begin errors++; $display("FAIL write_data: got %h expected a5", exec_log[0].data); end
            checks++; if (exec_log[0].addr !== 32'h04) begin errors++; $display("FAIL write_addr: got %h expected 4", exec_log[0].addr); end
        end
        checks++; if (unstable != 0) begin errors++; $display("FAIL write_cmd_stable: got %0d changes expected 0", unstable); end
        if (fin_log.size() > 0) begin
            checks++; if (fin_log[0].fin !== 4'b0001)        begin errors++; $display("FAIL write_fin: got %b expected 0001", fin_log[0].fin); end
            checks++; if (fin_log[0].rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL write_rdata_kept: got %h expected deadbeef", fin_log[0].rdata); end
        end
        checks++; if (req_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL write_rdata_after: got %h expected deadbeef", req_rdata); end
    endtask

    task automatic test_all_hold();
        bit ok;
        do_reset();
        clear_logs();
        hold_mask = 4'hF; drv_lat = 2; force_rd = 0;
        for (int i = 0; i < 4; i++) begin
            req_we[i] = 1'($urandom_range(0, 1));
            req_addr[i*32 +: 32] = 32'h100 * (i + 1);
            req_wdata[i*32 +: 32] = $urandom;
        end
        req_exec = 4'hF;
        run_fins(5, 100, ok);
        req_exec = '0;
        hold_mask = '0;
        checks++; if (!ok) begin errors++; $display("FAIL hold_timeout: got %0d fins expected 5", fin_log.size()); end
        idle_steps(6);
        checks++; if (exec_log.size() != 5) begin errors++; $display("FAIL hold_exec_count: got %0d expected 5", exec_log.size()); end
        for (int i = 0; i < 5 && i < exec_log.size() && i < fin_log.size(); i++) begin
            checks++; if (fin_log[i].fin !== 4'(1 << (i % 4))) begin errors++; $display("FAIL hold_order[%0d]: got %b expected %b", i, fin_log[i].fin, 4'(1 << (i % 4))); end
            checks++; if (exec_log[i].addr !== 32'h100 * ((i % 4) + 1)) begin errors++; $display("FAIL hold_addr[%0d]: got %h expected %h", i, exec_log[i].addr, 32'h100 * ((i % 4) + 1)); end
            if (i > 0) begin
                checks++; if (exec_log[i].cyc - exec_log[i-1].cyc != drv_lat + 3) begin errors++; $display("FAIL hold_spacing[%0d]: got %0d expected %0d", i, exec_log[i].cyc - exec_log[i-1].cyc, drv_lat + 3); end
            end
        end
    endtask

    task automatic test_drop();
        bit ok;
        int k = 0;
        clear_logs();
        drv_lat = 4; force_rd = 1; force_val = 32'hCAFE0003;
        req_we[3] = 1'b0; req_addr[96 +: 32] = 32'h3C;
        req_exec[3] = 1'b1;
        while (exec_log.size() == 0 && k < 10) begin step(); k++; end
        checks++; if (exec_log.size() == 0) begin errors++; $display("FAIL drop_grant_timeout: got 0 execs expected 1"); end
        req_exec[3] = 1'b0;
        run_fins(1, 30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL drop_timeout: got %0d fins expected 1", fin_log.size()); end
        idle_steps(4);
        if (fin_log.size() > 0) begin
            checks++; if (fin_log[0].fin !== 4'b1000)        begin errors++; $display("FAIL drop_fin: got %b expected 1000", fin_log[0].fin); end
            checks++; if (fin_log[0].rdata !== 32'hCAFE0003) begin errors++; $display("FAIL drop_rdata: got %h expected cafe0003", fin_log[0].rdata); end
        end
        checks++; if (exec_log.size() != 1) begin errors++; $display("FAIL drop_exec_count: got %0d expected 1", exec_log.size()); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [3:0] exp_fin [3] = '{4'b0010, 4'b1000, 4'b0010};
        do_reset();
        clear_logs();
        drv_lat = 1; force_rd = 0; hold_mask = 4'b0010;
        req_we[1] = 1'b0; req_addr[32 +: 32] = 32'h11;
        req_we[3] = 1'b1; req_addr[96 +: 32] = 32'h33; req_wdata[96 +: 32] = 32'h3333;
        req_exec = 4'b1010;
        run_fins(3, 60, ok);
        req_exec = '0;
        hold_mask = '0;
        checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: got %0d fins expected 3", fin_log.size()); end
        idle_steps(5);
        checks++; if (exec_log.size() != 3) begin errors++; $display("FAIL b2b_exec_count: got %0d expected 3", exec_log.size()); end
        for (int i = 0; i < 3 && i < fin_log.size(); i++) begin
            checks++; if (fin_log[i].fin !== exp_fin[i]) begin errors++; $display("FAIL b2b_order[%0d]: got %b expected %b", i, fin_log[i].fin, exp_fin[i]); end
        end
        for (int i = 1; i < 3 && i < exec_log.size(); i++) begin
            checks++; if (exec_log[i].cyc - exec_log[i-1].cyc < 3) begin errors++; $display("FAIL b2b_min_gap[%0d]: got %0d expected >=3", i, exec_log[i].cyc - exec_log[i-1].cyc); end
            checks++; if (exec_log[i].cyc - exec_log[i-1].cyc != drv_lat + 3) begin errors++; $display("FAIL b2b_gap[%0d]: got %0d expected %0d", i, exec_log[i].cyc - exec_log[i-1].cyc, drv_lat + 3); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int k = 0;
        clear_logs();
        drv_lat = 6; force_rd = 1; force_val = 32'h5555AAAA;
        req_we[2] = 1'b1; req_addr[64 +: 32] = 32'h20; req_wdata[64 +: 32] = 32'h77;
        req_exec[2] = 1'b1;
        while (exec_log.size() == 0 && k < 10) begin step(); k++; end
        checks++; if (exec_log.size() == 0) begin errors++; $display("FAIL rmid_grant_timeout: got 0 execs expected 1"); end
        step();
        step();
        checks++; if (m_we !== 1'b1) begin errors++; $display("FAIL rmid_pre_we: got %b expected 1", m_we); end
        nreset = 1'b0;
        #1;
        checks++; if ({m_exec, m_we, busy} !== 3'b000) begin errors++; $display("FAIL rmid_ctrl: got %b expected 000", {m_exec, m_we, busy}); end
        checks++; if (m_address !== '0 || m_data !== '0) begin errors++; $display("FAIL rmid_cmd: got %h/%h expected 0/0", m_address, m_data); end
        checks++; if (req_fin !== 4'b0000 || grant_id !== 2'd0) begin errors++; $display("FAIL rmid_grant: got %b/%0d expected 0000/0", req_fin, grant_id); end
        checks++; if (req_rdata !== '0) begin errors++; $display("FAIL rmid_rdata: got %h expected 0", req_rdata); end
        req_exec = '0;
        step();
        step();
        nreset = 1'b1;
        step();
        clear_logs();
        drv_lat = 2; force_val = 32'h0F0F0F0F;
        req_we[3] = 1'b0; req_addr[96 +: 32] = 32'h30;
        req_exec[3] = 1'b1;
        run_fins(1, 30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rmid_after_timeout: got %0d fins expected 1", fin_log.size()); end
        idle_steps(3);
        if (exec_log.size() > 0) begin
            checks++; if (exec_log[0].addr !== 32'h30 || exec_log[0].gid !== 2'd3) begin errors++; $display("FAIL rmid_after_cmd: got %h/%0d expected 30/3", exec_log[0].addr, exec_log[0].gid); end
        end
        if (fin_log.size() > 0) begin
            checks++; if (fin_log[0].fin !== 4'b1000 || fin_log[0].rdata !== 32'h0F0F0F0F) begin errors++; $display("FAIL rmid_after_fin: got %b/%h expected 1000/0f0f0f0f", fin_log[0].fin, fin_log[0].rdata); end
        end
    endtask

    task automatic test_random();
        int          k = 0;
        int          g;
        int          ptr = 0;
        logic [31:0] rd = '0;
        logic [31:0] exp_rd;
        do_reset();
        clear_logs();
        hold_mask = '0; rand_lat = 1; force_rd = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req_exec[i] && $urandom_range(0, 3) == 0) begin
                    req_we[i] = 1'($urandom_range(0, 1));
                    req_addr[i*32 +: 32] = $urandom;
                    req_wdata[i*32 +: 32] = $urandom;
                    req_exec[i] = 1'b1;
                end
            end
            step();
        end
        while ((req_exec != 4'b0000 || busy) && k < 200) begin step(); k++; end
        checks++; if (k >= 200) begin errors++; $display("FAIL rand_drain_timeout: got exec %b expected 0000", req_exec); end
        checks++; if (exec_log.size() != fin_log.size()) begin errors++; $display("FAIL rand_count: got %0d fins expected %0d", fin_log.size(), exec_log.size()); end
        checks++; if (unstable != 0) begin errors++; $display("FAIL rand_cmd_stable: got %0d changes expected 0", unstable); end
        for (int i = 0; i < exec_log.size() && i < fin_log.size(); i++) begin
            g = -1;
            for (int s = 0; s < 4; s++) begin
                if (g < 0 && exec_log[i].act[(ptr + s) % 4]) g = (ptr + s) % 4;
            end
            if (g < 0) g = 0;
            exp_rd = exec_log[i].we ? rd : fin_log[i].sent;
            checks++; if (exec_log[i].gid !== 2'(g)) begin errors++; $display("FAIL rand_grant[%0d]: got %0d expected %0d", i, exec_log[i].gid, g); end
            checks++; if (exec_log[i].addr !== exec_log[i].addrs[g*32 +: 32] || exec_log[i].we !== exec_log[i].wes[g] || exec_log[i].data !== exec_log[i].wds[g*32 +: 32])
                begin errors++; $display("FAIL rand_cmd[%0d]: got %h/%b/%h expected %h/%b/%h", i, exec_log[i].addr, exec_log[i].we, exec_log[i].data, exec_log[i].addrs[g*32 +: 32], exec_log[i].wes[g], exec_log[i].wds[g*32 +: 32]); end
            checks++; if (fin_log[i].fin !== 4'(1 << g)) begin errors++; $display("FAIL rand_fin[%0d]: got %b expected %b", i, fin_log[i].fin, 4'(1 << g)); end
            checks++; if (fin_log[i].rdata !== exp_rd) begin errors++; $display("FAIL rand_rdata[%0d]: got %h expected %h", i, fin_log[i].rdata, exp_rd); end
            checks++; if (fin_log[i].cyc - fin_log[i].mfin != 1) begin errors++; $display("FAIL rand_fin_latency[%0d]: got %0d expected 1", i, fin_log[i].cyc - fin_log[i].mfin); end
            rd  = exp_rd;
            ptr = (g + 1) % 4;
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_all_hold();
        test_drop();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
